// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types, mode codes and round-robin pick for the arithmetic scheduler
package arith_pkg;

  localparam logic [1:0] MODE_M1 = 2'd0;
  localparam logic [1:0] MODE_M2 = 2'd1;
  localparam logic [1:0] MODE_M3 = 2'd2;
  localparam logic [1:0] MODE_M4 = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] e;
    logic [1:0] mode;
  } operand_t;

  // Returns {found, index}: first set bit of valid at or after ptr, wrapping modulo n (n <= 8).
  function automatic logic [3:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                         input int n);
    logic [3:0] res;
    int         idx;
    res = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && valid[idx[2:0]]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/arith_core.sv
// rtl/arith_core.sv - combinational 4-bit multi-mode arithmetic datapath, 8-bit results
module arith_core
  import arith_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  input  logic [3:0] d,
  input  logic [3:0] e,
  input  logic [1:0] mode,
  output logic [7:0] y
);

  logic [7:0] za, zb, zc, zd, ze;
  logic [7:0] m1, m2, m3, m4;

  assign za = {4'b0, a};
  assign zb = {4'b0, b};
  assign zc = {4'b0, c};
  assign zd = {4'b0, d};
  assign ze = {4'b0, e};

  // Every intermediate is held at 8 bits so results wrap modulo 256.
  assign m1 = (za + zb) * (zc + zd);
  assign m2 = za * zc + zb * zd;
  assign m3 = ((za ^ zb) + zd) * (ze & 8'h02);
  assign m4 = (m1 + m2) ^ (m3 >> 2);

  always_comb begin
    y = m1;
    case (mode)
      MODE_M1: y = m1;
      MODE_M2: y = m2;
      MODE_M3: y = m3;
      MODE_M4: y = m4;
      default: y = m1;
    endcase
  end

endmodule

// File: rtl/arith_sched.sv
// rtl/arith_sched.sv - round-robin scheduler sharing one arith_core among NREQ requesters
module arith_sched
  import arith_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  input  logic [4*NREQ-1:0] req_c,
  input  logic [4*NREQ-1:0] req_d,
  input  logic [4*NREQ-1:0] req_e,
  input  logic [2*NREQ-1:0] req_mode,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, next_ptr, arb_ptr, grant_id, lat_id;
  operand_t       lat_op;
  logic [3:0]     pick;
  logic           can_accept, grant;
  logic [7:0]     core_y;

  // In RESP the handshake's pointer update is applied combinationally so re-arbitration
  // in the same cycle already sees it.
  assign next_ptr   = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
  assign arb_ptr    = (state == RESP) ? next_ptr : rr_ptr;
  assign pick       = rr_pick(8'(req_valid), 3'(arb_ptr), NREQ);
  assign grant_id   = IDW'(pick[2:0]);
  assign can_accept = rst_n && ((state == IDLE) || (state == RESP && rsp_ready));
  assign grant      = can_accept && pick[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = grant ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_id] = 1'b1;
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      lat_op    <= '0;
      lat_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_id    <= '0;
    end else begin
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= next_ptr;
      end
      if (grant) begin
        lat_op.a    <= req_a[{grant_id, 2'b00} +: 4];
        lat_op.b    <= req_b[{grant_id, 2'b00} +: 4];
        lat_op.c    <= req_c[{grant_id, 2'b00} +: 4];
        lat_op.d    <= req_d[{grant_id, 2'b00} +: 4];
        lat_op.e    <= req_e[{grant_id, 2'b00} +: 4];
        lat_op.mode <= req_mode[{grant_id, 1'b0} +: 2];
        lat_id      <= grant_id;
      end
      if (state == EXEC) begin
        rsp_data  <= core_y;
        rsp_id    <= lat_id;
        rsp_valid <= 1'b1;
      end
    end
  end

  arith_core u_core (
    .a    (lat_op.a),
    .b    (lat_op.b),
    .c    (lat_op.c),
    .d    (lat_op.d),
    .e    (lat_op.e),
    .mode (lat_op.mode),
    .y    (core_y)
  );

endmodule

// File: tb/tb_arith_sched.sv
// tb/tb_arith_sched.sv - randomized and directed self-checking bench for arith_sched
module tb_arith_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0, req_e = '0;
  logic [2*NREQ-1:0] req_mode = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [7:0]        rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gcyc = 0;

  arith_sched #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d), .req_e(req_e),
    .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_f(int a, int b, int c, int d, int e, int m);
    int m1, m2, m3, m4;
    m1 = ((a + b) * (c + d)) % 256;
    m2 = (a * c + b * d) % 256;
    m3 = (((a ^ b) + d) * (e & 2)) % 256;
    m4 = ((m1 + m2) % 256) ^ (m3 >> 2);
    case (m)
      0: return m1;
      1: return m2;
      2: return m3;
      default: return m4;
    endcase
  endfunction

  // Reference: at most one job is in flight; its result shows one cycle after acceptance
  // and stays until handshaken, when the slot frees and the pointer moves past its id.
  bit have_job = 0;
  int job_age, job_id, job_data, mptr = 0;
  int exp_v, acc, p, g, idx, exp_rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_job = 0;
      mptr = 0;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
    end else begin
      exp_v = (have_job && job_age >= 1) ? 1 : 0;
      chk("rsp_valid", rsp_valid, exp_v);
      chk("busy", busy, have_job);
      if (exp_v != 0) begin
        chk("rsp_data", rsp_data, job_data);
        chk("rsp_id", rsp_id, job_id);
      end
      acc = (!have_job || (exp_v != 0 && rsp_ready)) ? 1 : 0;
      p = have_job ? (job_id + 1) % NREQ : mptr;
      g = -1;
      if (acc != 0)
        for (int k = 0; k < NREQ; k++) begin
          idx = (p + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      exp_rdy = (g >= 0) ? (1 << g) : 0;
      chk("req_ready", req_ready, exp_rdy);
      if (have_job) job_age++;
      if (exp_v != 0 && rsp_ready) begin
        mptr = (job_id + 1) % NREQ;
        have_job = 0;
      end
      if (g >= 0) begin
        have_job = 1;
        job_age = 0;
        job_id = g;
        job_data = model_f(req_a[4*g +: 4], req_b[4*g +: 4], req_c[4*g +: 4],
                           req_d[4*g +: 4], req_e[4*g +: 4], req_mode[2*g +: 2]);
      end
    end
  end

  task automatic set_req(input int i, input int a, input int b, input int c, input int d,
                         input int e, input int m);
    req_a[4*i +: 4] = 4'(a);
    req_b[4*i +: 4] = 4'(b);
    req_c[4*i +: 4] = 4'(c);
    req_d[4*i +: 4] = 4'(d);
    req_e[4*i +: 4] = 4'(e);
    req_mode[2*i +: 2] = 2'(m);
    req_valid[i] = 1'b1;
  endtask

  task automatic set_rand(input int i);
    set_req(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
  endtask

  task automatic wait_grant(output int gi);
    bit found = 0;
    gi = -1;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        found = 1;
        gcyc = cyc;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) gi = k;
      end
    end
    if (!found) chk("grant_timeout", 0, 1);
    @(posedge clk); #1;
    if (gi >= 0) req_valid[gi] = 1'b0;
  endtask

  task automatic wait_rsp(output int data, output int id, output int lat);
    bit found = 0;
    data = -1; id = -1; lat = -1;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1;
        data = rsp_data;
        id = rsp_id;
        lat = cyc - gcyc;
      end
    end
    if (!found) chk("rsp_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int gi, d, id, lat, prev;
    int exp1[4] = '{21, 11, 14, 35};
    int fair[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    logic [NREQ-1:0] gm;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;

    for (int m = 0; m < 4; m++) begin
      set_req(0, 1, 2, 3, 4, 2, m);
      wait_grant(gi);
      chk("single_grant", gi, 0);
      wait_rsp(d, id, lat);
      chk("single_data", d, exp1[m]);
      chk("single_id", id, 0);
      chk("single_latency", lat, 2);
    end

    set_req(0, 15, 15, 15, 15, 1, 0);
    wait_grant(gi);
    wait_rsp(d, id, lat);
    chk("overflow_m1", d, 132);
    set_req(0, 15, 15, 15, 15, 1, 2);
    wait_grant(gi);
    wait_rsp(d, id, lat);
    chk("overflow_m3", d, 0);

    for (int i = 0; i < NREQ; i++) set_rand(i);
    prev = -1;
    for (int n = 0; n < 8; n++) begin
      wait_grant(gi);
      chk("fair_order", gi, fair[n]);
      if (n > 0) chk("fair_spacing", gcyc - prev, 2);
      prev = gcyc;
      if (n < 7 && gi >= 0) set_rand(gi);
    end
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    set_req(1, 3, 5, 7, 9, 2, 3);
    wait_grant(gi);
    chk("bp_first_grant", gi, 1);
    rsp_ready = 1'b0;
    set_req(2, 6, 1, 2, 8, 3, 1);
    repeat (6) begin
      @(negedge clk);
      chk("bp_req_ready_low", req_ready, 0);
    end
    chk("bp_rsp_id_held", rsp_id, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    gcyc = cyc - 1;
    wait_rsp(d, id, lat);
    chk("bp_second_id", id, 2);
    chk("bp_second_data", d, model_f(6, 1, 2, 8, 3, 1));

    set_req(3, 2, 2, 2, 2, 2, 0);
    wait_grant(gi);
    wait_rsp(d, id, lat);
    chk("wrap_served_id", id, 3);
    set_req(0, 1, 1, 1, 1, 0, 0);
    set_req(3, 4, 4, 4, 4, 0, 0);
    wait_grant(gi);
    chk("wrap_first", gi, 0);
    wait_grant(gi);
    chk("wrap_second", gi, 3);
    repeat (4) @(posedge clk);
    #1;

    set_req(1, 1, 1, 1, 1, 1, 1);
    wait_grant(gi);
    wait_rsp(d, id, lat);
    set_req(2, 5, 5, 5, 5, 5, 0);
    wait_grant(gi);
    chk("rst_pre_busy", busy, 1);
    set_req(3, 7, 7, 7, 7, 7, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", rsp_valid, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(1, 2, 3, 4, 5, 6, 2);
    wait_grant(gi);
    chk("rst_after_grant", gi, 1);
    wait_rsp(d, id, lat);
    chk("rst_after_id", id, 1);
    chk("rst_after_data", d, model_f(2, 3, 4, 5, 6, 2));
    chk("rst_after_latency", lat, 2);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      gm = req_ready;
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (gm[i]) begin
          req_valid[i] = 1'b0;
          if ($urandom_range(0, 1) == 0) set_rand(i);
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) set_rand(i);
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
